// File: rtl/cla_nibble_serial_adder.sv
// Multi-cycle adder: streams WIDTH-bit operands one nibble per cycle through a single
// 4-bit carry-lookahead slice, with valid/ready handshakes on both sides.
module cla_nibble_serial_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int unsigned Nib  = WIDTH / 4;
  localparam int unsigned IdxW = (Nib > 1) ? $clog2(Nib) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(Nib - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic              carry_q, carry_d, c_out_q, c_out_d, ovf_q, ovf_d;
  logic [IdxW-1:0]   idx_q, idx_d;

  // Slice operands and results
  logic [3:0] x, y, g, p, c, s;
  logic       g_dot, p_dot, carry_out;

  assign x = a_q[4*idx_q +: 4];
  assign y = b_q[4*idx_q +: 4];

  // 4-bit carry-lookahead slice; c[3] is the carry into the slice MSB
  always_comb begin
    g         = x & y;
    p         = x ^ y;
    c[0]      = carry_q;
    c[1]      = g[0] | (p[0] & c[0]);
    c[2]      = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3]      = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
    s         = p ^ c;
    g_dot     = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    p_dot     = &p;
    carry_out = g_dot | (p_dot & carry_q);
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sum_d[4*idx_q +: 4] = s;
        carry_d             = carry_out;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          c_out_d = carry_out;
          ovf_d   = c[3] ^ carry_out;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_nibble_serial_adder.sv
// Self-checking bench for cla_nibble_serial_adder: directed corner cases plus a random
// stream, each result compared against a plain-arithmetic reference.
module tb_cla_nibble_serial_adder;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst, in_valid, in_ready, c_in, out_valid, out_ready, c_out, overflow;
  logic [WIDTH-1:0] a, b, sum;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cla_nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .c_out    (c_out),
    .overflow (overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: full-precision addition, signed overflow from operand/result signs
  task automatic model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                       output logic [WIDTH-1:0] s, output logic co, output logic ov);
    logic [WIDTH:0] t;
    t  = {1'b0, x} + {1'b0, y} + (WIDTH+1)'(ci);
    s  = t[WIDTH-1:0];
    co = t[WIDTH];
    ov = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
  endtask

  // Called at a negedge; returns at a negedge with the block back in IDLE
  task automatic run_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic ci,
                        input int hold);
    logic [WIDTH-1:0] es;
    logic             eco, eov;
    int               w, lat;
    model(x, y, ci, es, eco, eov);
    a        = x;
    b        = y;
    c_in     = ci;
    in_valid = 1'b1;
    w = 0;
    while (!in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    check_eq("accept_wait", 32'(w < 100), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    a        = WIDTH'($urandom);
    b        = WIDTH'($urandom);
    c_in     = 1'($urandom);
    check_eq("in_ready_run", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    check_eq("latency", 32'(lat), 32'(NIB));
    check_eq("sum", 32'(sum), 32'(es));
    check_eq("c_out", 32'(c_out), 32'(eco));
    check_eq("overflow", 32'(overflow), 32'(eov));
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a        = WIDTH'($urandom);
      b        = WIDTH'($urandom);
      @(negedge clk);
      check_eq("hold_valid", 32'(out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(in_ready), 32'd0);
      check_eq("hold_sum", 32'(sum), 32'(es));
      check_eq("hold_flags", 32'({c_out, overflow}), 32'({eco, eov}));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("out_valid_drop", 32'(out_valid), 32'd0);
    check_eq("in_ready_idle", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_sum", 32'(sum), 32'd0);
    check_eq("rst_flags", 32'({c_out, overflow}), 32'd0);

    run_op(16'h1234, 16'h4321, 1'b0, 0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 0);
    run_op(16'h7FFF, 16'h0001, 1'b0, 0);
    run_op(16'h8000, 16'h8000, 1'b0, 0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1, 3);

    // Reset during the second RUN cycle discards the add
    a        = 16'hAAAA;
    b        = 16'h5555;
    c_in     = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check_eq("midrun_out_valid", 32'(out_valid), 32'd0);
    check_eq("midrun_in_ready", 32'(in_ready), 32'd1);
    check_eq("midrun_sum", 32'(sum), 32'd0);
    check_eq("midrun_flags", 32'({c_out, overflow}), 32'd0);
    run_op(16'h0F0F, 16'h0101, 1'b0, 0);
    check_eq("post_rst_sum", 32'(sum), 32'h1010);

    for (int i = 0; i < 20; i++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
